// File: rtl/sprite_draw_if.sv
// Shared pixel/handshake bus between the animator clients and the draw scheduler.
// The scheduler drives go_out and the VGA plot port; the clients drive everything else.
interface sprite_draw_if #(
    parameter int N_CLIENTS = 4,
    parameter int COLOUR_W  = 3
);
    logic [N_CLIENTS-1:0]          req;
    logic [N_CLIENTS-1:0]          done_in;
    logic [N_CLIENTS-1:0]          plot_in;
    logic [8*N_CLIENTS-1:0]        x_in;
    logic [7*N_CLIENTS-1:0]        y_in;
    logic [COLOUR_W*N_CLIENTS-1:0] colour_in;
    logic [N_CLIENTS-1:0]          go_out;
    logic [7:0]                    vga_x;
    logic [6:0]                    vga_y;
    logic [COLOUR_W-1:0]           vga_colour;
    logic                          vga_plot;

    modport master (
        input  req, done_in, plot_in, x_in, y_in, colour_in,
        output go_out, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        output req, done_in, plot_in, x_in, y_in, colour_in,
        input  go_out, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/sprite_draw_scheduler.sv
// Frame-paced sequencer that hands the single VGA plot port to each active animator
// in ascending index order, with a per-grant watchdog and frame-overrun detection.
module sprite_draw_scheduler #(
    parameter int N_CLIENTS      = 4,
    parameter int COLOUR_W       = 3,
    parameter int FRAME_CYCLES   = 833334,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 enable,
    sprite_draw_if.master        bus,
    output logic                 frame_tick,
    output logic                 busy,
    output logic                 overrun,
    output logic [N_CLIENTS-1:0] timeout
);
    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int FRM_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_CLIENTS - 1);
    localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(FRAME_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_NEXT
    } state_t;

    state_t               state, state_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [FRM_W-1:0]     frame_cnt;
    logic [WD_W-1:0]      wd_cnt, wd_n;
    logic [N_CLIENTS-1:0] idx_onehot;
    logic [N_CLIENTS-1:0] timeout_set;
    logic                 overrun_set;

    logic                 sel_req;
    logic                 sel_done;
    logic                 sel_plot;
    logic [7:0]           sel_x;
    logic [6:0]           sel_y;
    logic [COLOUR_W-1:0]  sel_colour;

    assign frame_tick  = (frame_cnt == FRAME_LAST);
    assign busy        = (state != S_IDLE);
    assign overrun_set = frame_tick && (state != S_IDLE);

    // Client selection by the current index; loop keeps every select in range for any N.
    always_comb begin
        idx_onehot = '0;
        sel_req    = 1'b0;
        sel_done   = 1'b0;
        sel_plot   = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (idx == IDX_W'(i)) begin
                idx_onehot[i] = 1'b1;
                sel_req       = bus.req[i];
                sel_done      = bus.done_in[i];
                sel_plot      = bus.plot_in[i];
                sel_x         = bus.x_in[8*i +: 8];
                sel_y         = bus.y_in[7*i +: 7];
                sel_colour    = bus.colour_in[COLOUR_W*i +: COLOUR_W];
            end
        end
    end

    // The VGA port is only ever driven by the granted client, with no register in the path.
    always_comb begin
        bus.go_out     = (state == S_ISSUE) ? idx_onehot : '0;
        bus.vga_plot   = (state == S_WAIT) ? sel_plot : 1'b0;
        bus.vga_x      = (state == S_WAIT) ? sel_x : '0;
        bus.vga_y      = (state == S_WAIT) ? sel_y : '0;
        bus.vga_colour = (state == S_WAIT) ? sel_colour : '0;
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        wd_n        = wd_cnt;
        timeout_set = '0;
        case (state)
            S_IDLE: begin
                if (frame_tick && enable) begin
                    state_n = S_SCAN;
                    idx_n   = '0;
                end
            end
            S_SCAN: begin
                if (sel_req) begin
                    state_n = S_ISSUE;
                end else if (idx == LAST_IDX) begin
                    state_n = S_IDLE;
                end else begin
                    idx_n = idx + IDX_W'(1);
                end
            end
            S_ISSUE: begin
                wd_n    = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the watchdog's last cycle wins over the abort.
                if (sel_done) begin
                    state_n = S_NEXT;
                end else if (wd_cnt == WD_LAST) begin
                    timeout_set = idx_onehot;
                    state_n     = S_NEXT;
                end else begin
                    wd_n = wd_cnt + WD_W'(1);
                end
            end
            S_NEXT: begin
                if (idx == LAST_IDX) begin
                    state_n = S_IDLE;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    state_n = S_SCAN;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= S_IDLE;
            idx       <= '0;
            wd_cnt    <= '0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
            timeout   <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            wd_cnt    <= wd_n;
            frame_cnt <= frame_tick ? '0 : frame_cnt + FRM_W'(1);
            overrun   <= overrun | overrun_set;
            timeout   <= timeout | timeout_set;
        end
    end
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler: client models plus a queue-based scoreboard
// for go pulses, VGA pixels and frame ticks; a second instance exercises frame overrun.
module tb_sprite_draw_scheduler;
    localparam int N  = 4;
    localparam int CW = 3;
    localparam int FC = 100;
    localparam int TC = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    logic         frame_tick, busy, overrun;
    logic [N-1:0] timeout;
    logic         ov_tick, ov_busy, ov_overrun;
    logic [N-1:0] ov_timeout;

    sprite_draw_if #(.N_CLIENTS(N), .COLOUR_W(CW)) bus ();
    sprite_draw_if #(.N_CLIENTS(N), .COLOUR_W(CW)) ov_bus ();

    sprite_draw_scheduler #(
        .N_CLIENTS(N), .COLOUR_W(CW), .FRAME_CYCLES(FC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clock(clk), .resetn(resetn), .enable(enable), .bus(bus),
        .frame_tick(frame_tick), .busy(busy), .overrun(overrun), .timeout(timeout)
    );

    // Long watchdog so a client can outlast a whole frame.
    sprite_draw_scheduler #(
        .N_CLIENTS(N), .COLOUR_W(CW), .FRAME_CYCLES(FC), .TIMEOUT_CYCLES(256)
    ) dut_ov (
        .clock(clk), .resetn(resetn), .enable(enable), .bus(ov_bus),
        .frame_tick(ov_tick), .busy(ov_busy), .overrun(ov_overrun), .timeout(ov_timeout)
    );

    int checks = 0;
    int errors = 0;
    int cyc;
    int go_q[$];
    logic [17:0] pix_q[$];
    int tick_q[$];

    int   dly[N];
    int   cd[N];
    logic pix_en = 1'b0;
    int   ov_dly = 120;
    int   ov_cd = 0;
    int   ov_go_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic to_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    always @(posedge clk) begin
        if (!resetn) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Client models: done arrives dly[i] cycles after go (0 = never answers).
    always @(negedge clk) begin : clients
        logic [N-1:0] d, p;
        d = '0;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.go_out[i]) begin
                cd[i] = dly[i];
            end else if (cd[i] > 0) begin
                cd[i] = cd[i] - 1;
                if (cd[i] == 0) d[i] = 1'b1;
                if (pix_en && i == 2 && cd[i] == 2) p = 4'b0101;
            end
        end
        bus.done_in = d;
        bus.plot_in = p;
    end

    always @(negedge clk) begin : ov_client
        logic [N-1:0] d;
        d = '0;
        if (ov_bus.go_out[0]) begin
            ov_go_cnt = ov_go_cnt + 1;
            ov_cd = ov_dly;
        end else if (ov_cd > 0) begin
            ov_cd = ov_cd - 1;
            if (ov_cd == 0) d[0] = 1'b1;
        end
        ov_bus.done_in = d;
    end

    // Scoreboard monitor: pops an expectation whenever the DUT presents an event.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resetn) begin
                if (bus.go_out != '0) begin
                    if (go_q.size() == 0) check("go_unexpected", 64'(bus.go_out), 64'(0));
                    else check("go_index", 64'(bus.go_out), 64'(1) << go_q.pop_front());
                end
                if (bus.vga_plot) begin
                    if (pix_q.size() == 0) check("pix_unexpected", 64'(bus.vga_x), 64'(0));
                    else check("pix_xyc", 64'({bus.vga_x, bus.vga_y, bus.vga_colour}),
                               64'(pix_q.pop_front()));
                end
                if (frame_tick) begin
                    if (tick_q.size() == 0) check("tick_unexpected", 64'(cyc), 64'(0));
                    else check("tick_cycle", 64'(cyc), 64'(tick_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL bench_timeout: simulation time limit reached, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) dly[i] = 5;
        bus.req          = '0;
        bus.x_in         = {8'd0, 8'd40, 8'd0, 8'd99};
        bus.y_in         = {7'd0, 7'd30, 7'd0, 7'd11};
        bus.colour_in    = {3'd0, 3'd5, 3'd0, 3'd2};
        ov_bus.req       = 4'b0001;
        ov_bus.plot_in   = '0;
        ov_bus.x_in      = '0;
        ov_bus.y_in      = '0;
        ov_bus.colour_in = '0;

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({bus.go_out, busy, frame_tick, overrun, timeout,
                                  bus.vga_plot, bus.vga_x, ov_overrun, ov_busy}), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        enable = 1'b1;
        for (int f = 0; f < 6; f++) tick_q.push_back(99 + 100 * f);

        // Empty pass: four SCAN cycles then idle.
        for (int c = 100; c < 104; c++) begin
            to_cycle(c);
            check("busy_scan", 64'(busy), 64'(1));
        end
        to_cycle(104);
        check("busy_after_scan", 64'(busy), 64'(0));

        to_cycle(150);
        check("ov_overrun_clear", 64'(ov_overrun), 64'(0));
        bus.req = 4'b0101;
        pix_en  = 1'b1;
        go_q.push_back(0);
        go_q.push_back(2);
        pix_q.push_back({8'd40, 7'd30, 3'd5});

        to_cycle(205);
        check("ov_overrun_set", 64'(ov_overrun), 64'(1));
        check("ov_go_count_1", 64'(ov_go_cnt), 64'(1));

        to_cycle(230);
        check("idle_after_pass", 64'(busy), 64'(0));
        check("ov_idle", 64'(ov_busy), 64'(0));
        pix_en = 1'b0;

        to_cycle(250);
        ov_dly  = 5;
        bus.req = 4'b0011;
        dly[1]  = 0;
        go_q.push_back(0);
        go_q.push_back(1);

        to_cycle(298);
        check("ov_tick_dropped", 64'(ov_go_cnt), 64'(1));
        to_cycle(310);
        check("ov_next_pass", 64'(ov_go_cnt), 64'(2));
        to_cycle(320);
        check("timeout_pending", 64'(timeout), 64'(0));
        to_cycle(330);
        check("timeout_client1", 64'(timeout), 64'(4'b0010));
        check("pass_end_after_abort", 64'(busy), 64'(0));

        to_cycle(350);
        dly[1] = 5;
        go_q.push_back(0);
        go_q.push_back(1);
        to_cycle(430);
        check("pass_after_timeout", 64'(busy), 64'(0));
        check("timeout_sticky", 64'(timeout), 64'(4'b0010));

        // Client 2 answers on the watchdog's final cycle.
        to_cycle(450);
        bus.req = 4'b0100;
        dly[2]  = 16;
        go_q.push_back(2);
        to_cycle(525);
        check("done_beats_timeout", 64'(timeout), 64'(4'b0010));
        check("idle_after_coincide", 64'(busy), 64'(0));

        to_cycle(550);
        go_q.push_back(2);
        to_cycle(615);
        check("ov_overrun_sticky", 64'(ov_overrun), 64'(1));
        check("main_no_overrun", 64'(overrun), 64'(0));
        check("tick_q_drained", 64'(tick_q.size()), 64'(0));
        check("pix_q_drained", 64'(pix_q.size()), 64'(0));

        to_cycle(619);
        check("busy_in_wait", 64'(busy), 64'(1));
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid_wait", 64'({bus.go_out, busy, frame_tick, overrun, timeout,
                                     bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}),
              64'(0));
        check("ov_reset", 64'({ov_overrun, ov_busy, ov_timeout}), 64'(0));
        check("go_q_drained", 64'(go_q.size()), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
